// File: rtl/median_pkg.sv
// Shared types for the 3x3 median sequencer: pixel width, FSM states and the
// sorted-column history entry.
package median_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SORT,
    ST_LO,
    ST_MID,
    ST_HI,
    ST_FIN,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] hi;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] lo;
  } hist_entry_t;

endpackage

// File: rtl/median3x3_sched_sort3.sv
// Combinational unsigned 3-input sorter; every state of the sequencer shares
// this single instance.
module sort3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] hi,
  output logic [W-1:0] mid,
  output logic [W-1:0] lo
);

  logic [W-1:0] ab_hi, ab_lo, rest;
  logic         a_gt_b, abh_gt_c, abl_gt_rest;

  // Order a/b first, then c against the larger; the two leftovers give mid/lo.
  assign a_gt_b      = a > b;
  assign ab_hi       = a_gt_b ? a : b;
  assign ab_lo       = a_gt_b ? b : a;
  assign abh_gt_c    = ab_hi > c;
  assign hi          = abh_gt_c ? ab_hi : c;
  assign rest        = abh_gt_c ? c : ab_hi;
  assign abl_gt_rest = ab_lo > rest;
  assign mid         = abl_gt_rest ? ab_lo : rest;
  assign lo          = abl_gt_rest ? rest : ab_lo;

endmodule

// File: rtl/median3x3_sched.sv
// 3x3 median sequencer: sorts each incoming column, keeps the last three sorted
// columns and reduces them to the window median over five sorter passes.
module median3x3_sched
  import median_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sol,
  input  logic [W-1:0] in_y1,
  input  logic [W-1:0] in_y0,
  input  logic [W-1:0] in_ym1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_m
);

  if (W != PIX_W) begin : g_width_check
    $error("median3x3_sched: W must equal median_pkg::PIX_W");
  end

  state_t       state_q, state_d;
  logic [1:0]   fill_q, fill_d, fill_inc;
  hist_entry_t  col_q, col_d;
  hist_entry_t  hist_q [3];
  hist_entry_t  hist_d [3];
  logic [W-1:0] r_lo_q, r_lo_d, r_mid_q, r_mid_d, r_hi_q, r_hi_d;
  logic [W-1:0] out_m_q, out_m_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] s_a, s_b, s_c, s_hi, s_mid, s_lo;

  sort3 #(.W(W)) u_sort3 (
    .a   (s_a),
    .b   (s_b),
    .c   (s_c),
    .hi  (s_hi),
    .mid (s_mid),
    .lo  (s_lo)
  );

  // Sorter input selection: one consumer per state.
  always_comb begin
    s_a = '0;
    s_b = '0;
    s_c = '0;
    unique case (state_q)
      ST_SORT: begin s_a = col_q.hi;     s_b = col_q.mid;     s_c = col_q.lo;     end
      ST_LO:   begin s_a = hist_q[0].lo;  s_b = hist_q[1].lo;  s_c = hist_q[2].lo;  end
      ST_MID:  begin s_a = hist_q[0].mid; s_b = hist_q[1].mid; s_c = hist_q[2].mid; end
      ST_HI:   begin s_a = hist_q[0].hi;  s_b = hist_q[1].hi;  s_c = hist_q[2].hi;  end
      ST_FIN:  begin s_a = r_lo_q;        s_b = r_mid_q;       s_c = r_hi_q;        end
      default: ;
    endcase
  end

  assign fill_inc = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;

  // Median of the window = median of (max of lows, median of mids, min of highs).
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    col_d       = col_q;
    hist_d      = hist_q;
    r_lo_d      = r_lo_q;
    r_mid_d     = r_mid_q;
    r_hi_d      = r_hi_q;
    out_m_d     = out_m_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          col_d   = '{hi: in_y1, mid: in_y0, lo: in_ym1};
          fill_d  = in_sol ? 2'd0 : fill_q;
          state_d = ST_SORT;
        end
      end
      ST_SORT: begin
        hist_d[0] = '{hi: s_hi, mid: s_mid, lo: s_lo};
        hist_d[1] = hist_q[0];
        hist_d[2] = hist_q[1];
        fill_d    = fill_inc;
        state_d   = (fill_inc == 2'd3) ? ST_LO : ST_IDLE;
      end
      ST_LO: begin
        r_lo_d  = s_hi;
        state_d = ST_MID;
      end
      ST_MID: begin
        r_mid_d = s_mid;
        state_d = ST_HI;
      end
      ST_HI: begin
        r_hi_d  = s_lo;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        out_m_d     = s_mid;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fill_q      <= 2'd0;
      col_q       <= '0;
      r_lo_q      <= '0;
      r_mid_q     <= '0;
      r_hi_q      <= '0;
      out_m_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) hist_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      col_q       <= col_d;
      r_lo_q      <= r_lo_d;
      r_mid_q     <= r_mid_d;
      r_hi_q      <= r_hi_d;
      out_m_q     <= out_m_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 3; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_m     = out_m_q;

endmodule

// File: tb/tb_median3x3_sched.sv
// Randomised self-checking bench for median3x3_sched against a 9-pixel sort
// reference of the last three accepted columns.
module tb_median3x3_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sol = 1'b0;
  logic [7:0] in_y1 = '0, in_y0 = '0, in_ym1 = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_m;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] cols[$];

  median3x3_sched #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sol    (in_sol),
    .in_y1     (in_y1),
    .in_y0     (in_y0),
    .in_ym1    (in_ym1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_m     (out_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int median9(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    int v[9];
    int t;
    v[0] = int'(a[23:16]); v[1] = int'(a[15:8]); v[2] = int'(a[7:0]);
    v[3] = int'(b[23:16]); v[4] = int'(b[15:8]); v[5] = int'(b[7:0]);
    v[6] = int'(c[23:16]); v[7] = int'(c[15:8]); v[8] = int'(c[7:0]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_col(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input bit sol, output bit has_out, output int exp_m);
    int t = 0;
    in_y1 = a; in_y0 = b; in_ym1 = c; in_sol = sol; in_valid = 1'b1;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sol   = 1'b0;
    if (sol) cols.delete();
    cols.push_back({a, b, c});
    if (cols.size() > 3) void'(cols.pop_front());
    has_out = (cols.size() == 3);
    exp_m   = has_out ? median9(cols[0], cols[1], cols[2]) : 0;
    $display("col %0d,%0d,%0d sol=%0d -> %s %0d", a, b, c, sol, has_out ? "median" : "none", exp_m);
  endtask

  task automatic check_none(input bit stray_sol);
    @(negedge clk);
    chk("ready_after_sort", int'(in_ready), 1);
    chk("no_output", int'(out_valid), 0);
    if (stray_sol) begin
      in_sol = 1'b1;
      @(negedge clk);
      in_sol = 1'b0;
    end
  endtask

  task automatic finish_col(input int exp_m, input int bp, input bit pre, input logic [23:0] pre_col);
    int lat = 0;
    int low = 0;
    if (!in_ready) low++;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!in_ready) low++;
    end
    chk("latency", lat, 5);
    chk("out_m", int'(out_m), exp_m);
    for (int i = 0; i < bp; i++) begin
      if (pre) begin
        {in_y1, in_y0, in_ym1} = pre_col;
        in_valid = 1'b1;
      end else begin
        in_sol = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (!in_ready) low++;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_m", int'(out_m), exp_m);
    end
    if (!pre) in_sol = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ready_low_cycles", low, 6 + bp);
    chk("out_cleared", int'(out_valid), 0);
    chk("ready_back", int'(in_ready), 1);
  endtask

  task automatic run_col(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input bit sol, input int bp);
    bit has_out;
    int exp_m;
    send_col(a, b, c, sol, has_out, exp_m);
    if (has_out) finish_col(exp_m, bp, 1'b0, 24'd0);
    else check_none(1'b0);
  endtask

  initial begin
    bit has_out;
    int exp_m;

    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_m", int'(out_m), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_col(8'd10, 8'd20, 8'd30, 1'b1, 0);
    run_col(8'd40, 8'd50, 8'd60, 1'b0, 0);
    run_col(8'd70, 8'd80, 8'd90, 1'b0, 0);
    run_col(8'd0,  8'd0,  8'd0,  1'b0, 0);

    // Long backpressure with the next column already on the input.
    send_col(8'd1, 8'd2, 8'd3, 1'b0, has_out, exp_m);
    chk("bp_has_out", int'(has_out), 1);
    finish_col(exp_m, 10, 1'b1, {8'd9, 8'd9, 8'd9});
    run_col(8'd9, 8'd9, 8'd9, 1'b0, 0);

    run_col(8'd5,   8'd5, 8'd5,   1'b1, 0);
    run_col(8'd5,   8'd5, 8'd5,   1'b0, 0);
    run_col(8'd200, 8'd1, 8'd100, 1'b0, 0);

    run_col(8'd7,   8'd7, 8'd7,   1'b1, 0);
    run_col(8'd7,   8'd7, 8'd7,   1'b0, 0);
    run_col(8'd7,   8'd7, 8'd7,   1'b0, 1);
    run_col(8'd255, 8'd0, 8'd128, 1'b0, 2);

    // Reset while the FSM sits in FIN.
    send_col(8'd11, 8'd22, 8'd33, 1'b0, has_out, exp_m);
    chk("fin_has_out", int'(has_out), 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("fin_rst_valid", int'(out_valid), 0);
    chk("fin_rst_ready", int'(in_ready), 1);
    @(negedge clk);
    chk("fin_rst_hold", int'(out_valid), 0);
    rst_n = 1'b1;
    cols.delete();
    @(negedge clk);
    run_col(8'd100, 8'd150, 8'd200, 1'b0, 0);
    run_col(8'd3,   8'd250, 8'd60,  1'b0, 0);
    run_col(8'd90,  8'd17,  8'd42,  1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [7:0] a, b, c;
      bit sol;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = a;
      sol = ($urandom_range(0, 9) == 0);
      send_col(a, b, c, sol, has_out, exp_m);
      if (has_out) finish_col(exp_m, int'($urandom_range(0, 3)), 1'b0, 24'd0);
      else check_none(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
